dsi_lp_hs_seq: RTL

Parametrised multi-lane DSI data-lane LP-to-HS entry/exit sequencer. It buffers an HS burst in an internal synchronous FIFO while driving the LP-11 -> LP-01 -> LP-00 -> HS-0 preamble. It then streams the buffered words and closes the burst with HS-trail and LP-11 exit timing, neither of which the previous generation generated. It sits between the DSI packet builder and the per-lane HS serialisers / LP drivers.

---
 rtl/dsi_lp_hs_seq_if.sv | 25 ++
 rtl/dsi_lp_hs_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dsi_lp_hs_seq_if.sv
// Handshake/bus bundle between the DSI packet builder and the LP/HS sequencer.
// The packet builder drives through the master modport; the sequencer uses slave.
interface dsi_lp_hs_seq_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 16 * LANES
);
  logic                 hs_en;
  logic [DATA_W-1:0]    hs_data_in;
  logic                 fifo_full;
  logic                 ovf;
  logic [2*LANES-1:0]   lp_data;
  logic                 hs_out_en;
  logic [DATA_W-1:0]    hs_data_out;
  logic                 busy;

  modport master (
    output hs_en, hs_data_in,
    input  fifo_full, ovf, lp_data, hs_out_en, hs_data_out, busy
  );

  modport slave (
    input  hs_en, hs_data_in,
    output fifo_full, ovf, lp_data, hs_out_en, hs_data_out, busy
  );
endinterface

// File: rtl/dsi_lp_hs_seq.sv
// Multi-lane DSI data-lane LP->HS entry/exit sequencer with an internal burst FIFO.
// Drives LP-01/LP-00/HS-0 preamble, streams buffered words, then HS-trail and LP-11 exit.
module dsi_lp_hs_seq #(
  parameter int LANES        = 2,
  parameter int DATA_W       = 16 * LANES,
  parameter int FIFO_DEPTH   = 256,
  parameter int T_LPX        = 5,
  parameter int T_HS_PREPARE = 2,
  parameter int T_HS_ZERO    = 11,
  parameter int T_HS_TRAIL   = 6,
  parameter int T_HS_EXIT    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  dsi_lp_hs_seq_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16;

  localparam logic [CW-1:0] LPX_LAST   = CW'(T_LPX - 1);
  localparam logic [CW-1:0] PREP_LAST  = CW'(T_HS_PREPARE - 1);
  localparam logic [CW-1:0] ZERO_LAST  = CW'(T_HS_ZERO - 1);
  localparam logic [CW-1:0] TRAIL_LAST = CW'(T_HS_TRAIL - 1);
  localparam logic [CW-1:0] EXIT_LAST  = CW'(T_HS_EXIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LPX   = 3'd1;
  localparam logic [2:0] S_PREP  = 3'd2;
  localparam logic [2:0] S_ZERO  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_TRAIL = 3'd5;
  localparam logic [2:0] S_EXIT  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              en_d0_q, en_d0_d;
  logic              en_d1_q, en_d1_d;
  logic              ovf_q, ovf_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              empty, full, wr_en, rd_en, start;
  logic [DATA_W-1:0] trail_word;
  logic [2*LANES-1:0] lp_data;
  logic              hs_out_en;
  logic [DATA_W-1:0] hs_data_out;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en = bus.hs_en & ~full;
  assign rd_en = ~empty & (state_q == S_DATA);
  assign start = en_d0_q & ~en_d1_q;

  always_comb begin
    en_d0_d   = bus.hs_en;
    en_d1_d   = en_d0_q;
    ovf_d     = ovf_q | (bus.hs_en & full);
    wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(rd_en);
    rd_vld_d  = rd_en;
    rd_data_d = rd_en ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
    last_d    = ((state_q == S_DATA) && rd_vld_q) ? rd_data_q : last_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start | ~empty) state_d = S_LPX;
      end
      S_LPX: if (cnt_q == LPX_LAST) begin
        state_d = S_PREP;
        cnt_d   = '0;
      end
      S_PREP: if (cnt_q == PREP_LAST) begin
        state_d = S_ZERO;
        cnt_d   = '0;
      end
      S_ZERO: if (cnt_q == ZERO_LAST) begin
        state_d = empty ? S_TRAIL : S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        cnt_d = '0;
        // Leave only once the final read word has already been presented.
        if (empty & ~rd_vld_q) state_d = S_TRAIL;
      end
      S_TRAIL: if (cnt_q == TRAIL_LAST) begin
        state_d = S_EXIT;
        cnt_d   = '0;
      end
      S_EXIT: if (cnt_q == EXIT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Trail level per lane is the inverse of that lane's final serialised bit.
  always_comb begin
    trail_word = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      trail_word[16*k +: 16] = {16{~last_q[16*k+15]}};
    end
  end

  always_comb begin
    lp_data     = '1;
    hs_out_en   = 1'b0;
    hs_data_out = '0;
    unique case (state_q)
      S_LPX:   lp_data = {LANES{2'b01}};
      S_PREP:  lp_data = '0;
      S_ZERO: begin
        lp_data   = '0;
        hs_out_en = 1'b1;
      end
      S_DATA: begin
        lp_data     = '0;
        hs_out_en   = 1'b1;
        hs_data_out = rd_vld_q ? rd_data_q : '0;
      end
      S_TRAIL: begin
        lp_data     = '0;
        hs_out_en   = 1'b1;
        hs_data_out = trail_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      en_d0_q   <= 1'b0;
      en_d1_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_d0_q   <= en_d0_d;
      en_d1_q   <= en_d1_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      last_q    <= last_d;
    end
  end

  // Storage is not reset; pointer reset alone discards the contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.hs_data_in;
  end

  assign bus.fifo_full   = full;
  assign bus.ovf         = ovf_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.lp_data     = lp_data;
  assign bus.hs_out_en   = hs_out_en;
  assign bus.hs_data_out = hs_data_out;

endmodule
